// File: rtl/alu_mc.sv
// Multi-cycle SISC ALU: single-cycle add/sub/logic/shift/rotate, plus an
// iterative shift-add unsigned multiplier behind a start/busy/done handshake.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic             start,
  input  logic [WIDTH-1:0] rsa,
  input  logic [WIDTH-1:0] rsb,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       stat,
  output logic             stat_en
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] F_ADD = 4'd1;
  localparam logic [3:0] F_SUB = 4'd2;
  localparam logic [3:0] F_NOT = 4'd4;
  localparam logic [3:0] F_OR  = 4'd5;
  localparam logic [3:0] F_AND = 4'd6;
  localparam logic [3:0] F_XOR = 4'd7;
  localparam logic [3:0] F_ROR = 4'd8;
  localparam logic [3:0] F_ROL = 4'd9;
  localparam logic [3:0] F_SHR = 4'd10;
  localparam logic [3:0] F_SHL = 4'd11;
  localparam logic [3:0] F_MUL = 4'd12;

  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nx;

  logic [3:0]         funct;
  logic [WIDTH-1:0]   imm_x, opb;
  logic               do_sub, ovf;
  logic [WIDTH:0]     sum;
  logic [SHAMT_W-1:0] amt;
  logic               big_shift;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c, sc_v, sc_rsvd, sc_sen;
  logic [3:0]         sc_stat;
  logic               is_mul;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod, prod_nx;
  logic [WIDTH:0]     mul_hi;
  logic [SHAMT_W-1:0] cnt;

  logic accept, load_sc, load_mul, last;

  assign funct  = imm[3:0];
  assign imm_x  = WIDTH'($signed(imm));
  assign is_mul = (alu_op == 2'b00) && (funct == F_MUL);

  // One WIDTH+1 adder serves add, sub and the immediate add; bit WIDTH is carry/borrow.
  always_comb begin
    do_sub = ~alu_op[0] & (funct == F_SUB);
    opb    = alu_op[0] ? imm_x : rsb;
    sum    = do_sub ? ({1'b0, rsa} - {1'b0, opb}) : ({1'b0, rsa} + {1'b0, opb});
    ovf    = ((rsa[WIDTH-1] ^ opb[WIDTH-1]) == do_sub) & (sum[WIDTH-1] ^ rsa[WIDTH-1]);
  end

  // Rotates fall out of a doubled operand; shifts saturate to zero past WIDTH-1.
  always_comb begin
    amt       = rsb[SHAMT_W-1:0];
    big_shift = |rsb[WIDTH-1:SHAMT_W];
    rot_r     = {rsa, rsa} >> amt;
    rot_l     = {rsa, rsa} << amt;
  end

  always_comb begin
    sc_res  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    sc_rsvd = 1'b0;
    if (alu_op[0]) begin
      sc_res = sum[WIDTH-1:0];
      sc_c   = sum[WIDTH];
      sc_v   = ovf;
    end else begin
      case (funct)
        F_ADD, F_SUB: begin
          sc_res = sum[WIDTH-1:0];
          sc_c   = sum[WIDTH];
          sc_v   = ovf;
        end
        F_NOT:   sc_res = ~rsa;
        F_OR:    sc_res = rsa | rsb;
        F_AND:   sc_res = rsa & rsb;
        F_XOR:   sc_res = rsa ^ rsb;
        F_ROR:   sc_res = rot_r[WIDTH-1:0];
        F_ROL:   sc_res = rot_l[2*WIDTH-1:WIDTH];
        F_SHR:   sc_res = big_shift ? '0 : (rsa >> amt);
        F_SHL:   sc_res = big_shift ? '0 : (rsa << amt);
        default: sc_rsvd = 1'b1;
      endcase
    end
    sc_stat = sc_rsvd ? 4'b0001 : {sc_c, sc_v, sc_res[WIDTH-1], ~|sc_res};
    sc_sen  = (alu_op == 2'b01) ||
              ((alu_op == 2'b00) && ((funct == F_ADD) || (funct == F_SUB)));
  end

  // prod = {partial high, remaining multiplier bits}; one multiplier bit retired per cycle.
  always_comb begin
    mul_hi  = prod[0] ? ({1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                      : {1'b0, prod[2*WIDTH-1:WIDTH]};
    prod_nx = {mul_hi, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && is_mul) state_nx = MUL;
      MUL:     if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == MUL);
    accept   = (state == IDLE) & start;
    load_mul = accept & is_mul;
    load_sc  = accept & ~is_mul;
    last     = (state == MUL) && (cnt == SHAMT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      mcand      <= '0;
      prod       <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      stat_en    <= 1'b0;
      alu_result <= '0;
      stat       <= '0;
    end else begin
      done    <= load_sc | last;
      stat_en <= (load_sc & sc_sen) | last;
      if (load_sc) begin
        alu_result <= sc_res;
        stat       <= sc_stat;
      end else if (last) begin
        alu_result <= prod_nx[WIDTH-1:0];
        stat       <= {|prod_nx[2*WIDTH-1:WIDTH], 1'b0, prod_nx[WIDTH-1], ~|prod_nx[WIDTH-1:0]};
      end
      if (load_mul) begin
        mcand <= rsa;
        prod  <= {{WIDTH{1'b0}}, rsb};
        cnt   <= '0;
      end else if (busy) begin
        prod <= prod_nx;
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expectations pushed at issue, popped on done.
module tb_alu_mc;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_f, start;
  logic [W-1:0]  rsa, rsb;
  logic [15:0]   imm;
  logic [1:0]    alu_op;
  logic          busy, done, stat_en;
  logic [W-1:0]  alu_result;
  logic [3:0]    stat;

  alu_mc #(.WIDTH(W), .IMM_W(16)) dut (
    .clk(clk), .rst_f(rst_f), .start(start), .rsa(rsa), .rsb(rsb), .imm(imm),
    .alu_op(alu_op), .busy(busy), .done(done), .alu_result(alu_result),
    .stat(stat), .stat_en(stat_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   st;
    logic         sen;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [15:0] im,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [3:0]  f;
    logic [31:0] bb, r;
    logic [32:0] s;
    logic [63:0] p;
    longint      sv;
    logic        c, v, rs;
    f = im[3:0]; c = 0; v = 0; rs = 0; r = '0; e.lat = 1;
    if (op[0] || f == 4'd1) begin
      bb = op[0] ? {{16{im[15]}}, im} : b;
      s  = {1'b0, a} + {1'b0, bb};
      r  = s[31:0]; c = s[32];
      sv = longint'($signed(a)) + longint'($signed(bb));
      v  = (sv != longint'($signed(r)));
    end else begin
      case (f)
        4'd2: begin
          r  = a - b; c = (a < b);
          sv = longint'($signed(a)) - longint'($signed(b));
          v  = (sv != longint'($signed(r)));
        end
        4'd4:  r = ~a;
        4'd5:  r = a | b;
        4'd6:  r = a & b;
        4'd7:  r = a ^ b;
        4'd8:  begin r = a; repeat (b % 32) r = {r[0], r[31:1]}; end
        4'd9:  begin r = a; repeat (b % 32) r = {r[30:0], r[31]}; end
        4'd10: r = (b >= 32) ? 32'd0 : a >> b;
        4'd11: r = (b >= 32) ? 32'd0 : a << b;
        4'd12: begin
          if (op == 2'b00) begin
            p = {32'd0, a} * {32'd0, b};
            r = p[31:0]; c = |p[63:32]; e.lat = 33;
          end else rs = 1;
        end
        default: rs = 1;
      endcase
    end
    e.res = r;
    e.st  = rs ? 4'b0001 : {c, v, r[31], r == 32'd0};
    e.sen = (op == 2'b01) || (op == 2'b00 && (f == 4'd1 || f == 4'd2 || f == 4'd12));
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_f && stat_en && !done) chk("stat_en_without_done", stat_en, 0);
    if (rst_f && done) begin
      if (sb.size() == 0) chk("unexpected_done", done, 0);
      else begin
        mon_e = sb.pop_front();
        chk("result", alu_result, mon_e.res);
        chk("stat", stat, mon_e.st);
        chk("stat_en", stat_en, mon_e.sen);
      end
    end
  end

  // Called on a negedge; start is held for one cycle, operands scrambled after capture.
  task automatic issue(input logic [1:0] op, input logic [15:0] im,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int n;
    e = model(op, im, a, b);
    sb.push_back(e);
    alu_op = op; imm = im; rsa = a; rsb = b; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0; rsa = $urandom; rsb = $urandom; imm = 16'($urandom);
    end while (!done && n < 60);
    chk("latency", n, e.lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0]  op;
    logic [3:0]  f;
    logic [31:0] a, b;
    rst_f = 0; start = 0; rsa = 0; rsb = 0; imm = 0; alu_op = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", alu_result, 0);
    chk("rst_stat", stat, 0);
    chk("rst_stat_en", stat_en, 0);
    rst_f = 1;
    @(negedge clk);

    issue(2'b00, 16'h0001, 32'h7fff_ffff, 32'h1);
    chk("add_ovf_res", alu_result, 32'h8000_0000);
    chk("add_ovf_stat", stat, 4'b0110);
    chk("add_ovf_sen", stat_en, 1);
    issue(2'b00, 16'h0002, 32'd5, 32'd5);
    chk("sub_zero_stat", stat, 4'b0001);
    issue(2'b01, 16'hffff, 32'h10, 32'h0);
    chk("addi_res", alu_result, 32'hf);
    chk("addi_sen", stat_en, 1);
    issue(2'b00, 16'h0009, 32'ha500_0000, 32'h24);
    chk("rotl_res", alu_result, 32'h5000_000a);
    chk("rotl_sen", stat_en, 0);
    issue(2'b00, 16'h000b, 32'h1, 32'd32);
    chk("shl32_res", alu_result, 0);
    chk("shl32_sen", stat_en, 0);
    issue(2'b00, 16'h0003, 32'h1234, 32'h5678);
    chk("rsvd_stat", stat, 4'b0001);

    issue(2'b00, 16'h000c, 32'h0000_ffff, 32'h0001_0001);
    chk("mul_res", alu_result, 32'hffff_ffff);
    chk("mul_stat", stat, 4'b0010);
    // back-to-back: start asserted in the done cycle
    issue(2'b00, 16'h000c, 32'h8000_0000, 32'h2);
    chk("mul_hi_stat", stat, 4'b1001);
    issue(2'b00, 16'h0007, 32'hff00_ff00, 32'h0f0f_0f0f);

    // start during busy must be dropped
    sb.push_back(model(2'b00, 16'h000c, 32'h0001_2345, 32'h0000_0abc));
    alu_op = 0; imm = 16'h000c; rsa = 32'h0001_2345; rsb = 32'h0000_0abc; start = 1;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    chk("busy_mid", busy, 1);
    alu_op = 0; imm = 16'h0001; rsa = 32'h1; rsb = 32'h1; start = 1;
    @(negedge clk); start = 0;
    n = 6;
    while (!done && n < 60) begin @(negedge clk); n++; end
    chk("busy_ignore_lat", n, 33);
    repeat (3) @(negedge clk);

    // reset in the middle of a multiply
    sb.push_back(model(2'b00, 16'h000c, 32'hdead_beef, 32'h1234_5678));
    alu_op = 0; imm = 16'h000c; rsa = 32'hdead_beef; rsb = 32'h1234_5678; start = 1;
    @(negedge clk); start = 0;
    repeat (9) @(negedge clk);
    rst_f = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", alu_result, 0);
    chk("mid_rst_stat", stat, 0);
    chk("mid_rst_sen", stat_en, 0);
    sb.delete();
    @(negedge clk); rst_f = 1;
    @(negedge clk);
    issue(2'b00, 16'h0001, 32'd40, 32'd2);
    chk("post_rst_res", alu_result, 32'd42);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 11))
        0: f = 4'd1;  1: f = 4'd2;  2: f = 4'd4;  3: f = 4'd5;
        4: f = 4'd6;  5: f = 4'd7;  6: f = 4'd8;  7: f = 4'd9;
        8: f = 4'd10; 9: f = 4'd11; 10: f = 4'd12; default: f = 4'd13;
      endcase
      if (op == 2'b10 && f == 4'd12) f = 4'd5;
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      issue(op, {12'($urandom), f}, a, b);
    end

    repeat (40) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
